// File: rtl/battle_ai_gen.sv
// AI opponent for the tug-of-war reaction game: fires one pbl_AI pulse per round,
// timed from DARK entry by difficulty level plus optional LFSR jitter.
module battle_ai_gen #(
  parameter int          CNT_W      = 11,
  parameter int          BASE_DELAY = 1199,
  parameter int          LEVEL_STEP = 256,
  parameter int          JITTER_W   = 8,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] state,
  input  logic       enable,
  input  logic [1:0] level,
  input  logic       jitter_en,
  output logic       pbl_AI,
  output logic       jumped,
  output logic       armed,
  output logic [7:0] press_cnt
);

  localparam int TW = CNT_W + 2;
  localparam logic [15:0]          SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic signed [TW-1:0] T_MIN    = TW'(1);
  localparam logic signed [TW-1:0] T_MAX    = TW'((1 << CNT_W) - 1);
  localparam logic signed [TW-1:0] BASE_S   = TW'(BASE_DELAY);
  localparam logic signed [TW-1:0] STEP_S   = TW'(LEVEL_STEP);

  typedef enum logic [1:0] {IDLE, ARMED, DONE} fsm_t;

  fsm_t                  fsm, fsm_n;
  logic [1:0]            state_q;
  logic [15:0]           lfsr;
  logic [CNT_W-1:0]      count, count_n;
  logic [CNT_W-1:0]      target, target_n, target_calc;
  logic                  pbl_n, jumped_n;
  logic [7:0]            press_n;
  logic                  round_start;
  logic signed [TW-1:0]  level_s, jitter_s, t_raw;

  assign round_start = (state == 2'b00) && (state_q != 2'b00) && enable;
  assign armed       = (fsm == ARMED);

  // Free-running Galois LFSR; its low bits supply jitter whenever a round starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr    <= SEED_EFF;
      state_q <= 2'b01;
    end else begin
      lfsr    <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      state_q <= state;
    end
  end

  // Signed headroom lets high levels go below 1 before clamping into the counter range.
  always_comb begin
    level_s  = $signed({{(TW-2){1'b0}}, level});
    jitter_s = '0;
    if (jitter_en) jitter_s = $signed({{(TW-JITTER_W){1'b0}}, lfsr[JITTER_W-1:0]});
    t_raw = BASE_S - level_s * STEP_S + jitter_s;
    if (t_raw < T_MIN)      target_calc = T_MIN[CNT_W-1:0];
    else if (t_raw > T_MAX) target_calc = T_MAX[CNT_W-1:0];
    else                    target_calc = t_raw[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      count     <= '0;
      target    <= '0;
      pbl_AI    <= 1'b0;
      jumped    <= 1'b0;
      press_cnt <= 8'd0;
    end else begin
      fsm       <= fsm_n;
      count     <= count_n;
      target    <= target_n;
      pbl_AI    <= pbl_n;
      jumped    <= jumped_n;
      press_cnt <= press_n;
    end
  end

  // Round start outranks the press check, so a rearm never fires on a stale target.
  always_comb begin
    fsm_n    = fsm;
    count_n  = count;
    target_n = target;
    pbl_n    = 1'b0;
    jumped_n = 1'b0;
    press_n  = press_cnt;
    if (!enable) begin
      fsm_n = IDLE;
    end else if (round_start) begin
      fsm_n    = ARMED;
      count_n  = '0;
      target_n = target_calc;
    end else if (state[0]) begin
      fsm_n = IDLE;
    end else if (fsm == ARMED) begin
      if (count == target) begin
        pbl_n    = 1'b1;
        jumped_n = (state == 2'b00);
        press_n  = (press_cnt == 8'hFF) ? press_cnt : press_cnt + 8'd1;
        fsm_n    = DONE;
      end else begin
        count_n = count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_battle_ai_gen.sv
// Self-checking bench for battle_ai_gen: scoreboarded press timing on the default
// instance, plus a short-delay instance for clamping and press_cnt saturation.
module tb_battle_ai_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state = 2'b01;
  logic       enable = 1'b0;
  logic [1:0] level = 2'd0;
  logic       jitter_en = 1'b0;
  logic       pbl_AI, jumped, armed;
  logic [7:0] press_cnt;

  logic [1:0] f_state = 2'b01;
  logic       f_enable = 1'b0;
  logic [1:0] f_level = 2'd0;
  logic       f_jitter_en = 1'b0;
  logic       f_pbl, f_jumped, f_armed;
  logic [7:0] f_press_cnt;

  battle_ai_gen dut (
    .clk(clk), .rst(rst), .state(state), .enable(enable), .level(level),
    .jitter_en(jitter_en), .pbl_AI(pbl_AI), .jumped(jumped), .armed(armed),
    .press_cnt(press_cnt)
  );

  battle_ai_gen #(.CNT_W(6), .BASE_DELAY(70), .LEVEL_STEP(24), .JITTER_W(4)) dut_fast (
    .clk(clk), .rst(rst), .state(f_state), .enable(f_enable), .level(f_level),
    .jitter_en(f_jitter_en), .pbl_AI(f_pbl), .jumped(f_jumped), .armed(f_armed),
    .press_cnt(f_press_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int delay;
    bit jumped;
  } exp_t;

  typedef struct {
    logic [1:0] lv;
    int         play_at;
    int         hold;
    int         exp_delay;
    bit         exp_jumped;
  } vec_t;

  typedef struct {
    logic [1:0] lv;
    int         exp_delay;
  } fvec_t;

  vec_t vecs[6] = '{
    '{2'd0, 0,   0,    1200, 1'b1},
    '{2'd0, 500, 5000, 1200, 1'b0},
    '{2'd3, 0,   0,    432,  1'b1},
    '{2'd2, 0,   0,    688,  1'b1},
    '{2'd1, 0,   0,    944,  1'b1},
    '{2'd3, 100, 0,    432,  1'b0}
  };

  fvec_t fvecs[4] = '{
    '{2'd0, 64}, '{2'd1, 47}, '{2'd2, 23}, '{2'd3, 2}
  };

  int          tests = 0;
  int          fails = 0;
  int          edge_cnt = 0;
  int          last_delay = 0;
  int          pulse_total = 0;
  int          exp_press = 0;
  bit          start_pending = 1'b0;
  logic        pbl_prev = 1'b0;
  logic [15:0] ref_lfsr;
  exp_t        sbq[$];
  exp_t        mon_e;

  // Reference 16-bit Galois LFSR (taps 0xB400) stepping every cycle from SEED.
  always @(posedge clk or posedge rst) begin
    if (rst) ref_lfsr <= 16'hACE1;
    else     ref_lfsr <= {1'b0, ref_lfsr[15:1]} ^ (ref_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // Edges since the most recent round-start edge (that edge itself is 0).
  always @(posedge clk) begin
    if (start_pending) begin
      edge_cnt      = 0;
      start_pending = 1'b0;
    end else begin
      edge_cnt++;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Scoreboard consumer: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && pbl_AI) begin
      pulse_total++;
      checkOutput("single_cycle_pulse", int'(pbl_prev), 0);
      if (sbq.size() == 0) begin
        checkOutput("unexpected_press_edge", edge_cnt, -1);
      end else begin
        mon_e      = sbq.pop_front();
        last_delay = edge_cnt;
        checkOutput("press_delay", edge_cnt, mon_e.delay);
        checkOutput("press_jumped", int'(jumped), int'(mon_e.jumped));
      end
    end
    pbl_prev = pbl_AI;
  end

  task automatic applyStimulus(input logic [1:0] st, input logic en,
                               input logic [1:0] lv, input logic je);
    @(negedge clk);
    state     = st;
    enable    = en;
    level     = lv;
    jitter_en = je;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    state = 2'b01;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic beginRound(input logic [1:0] lv, input bit je, input int base,
                            input bit exp_j, input bit push);
    exp_t e;
    applyStimulus(2'b00, 1'b1, lv, je);
    start_pending = 1'b1;
    if (push) begin
      e.delay  = base + (je ? int'(ref_lfsr[7:0]) : 0);
      e.jumped = exp_j;
      sbq.push_back(e);
      if (exp_press < 255) exp_press++;
    end
  endtask

  task automatic waitPress(input int limit);
    int n = 0;
    while (sbq.size() != 0 && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sbq.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL press_timeout: got no press in %0d cycles, expected one", limit);
      sbq.delete();
    end
  endtask

  task automatic fastRound(input logic [1:0] lv, output int d, output int j);
    int n = 0;
    @(negedge clk);
    f_state = 2'b01;
    @(negedge clk);
    f_state  = 2'b00;
    f_level  = lv;
    f_enable = 1'b1;
    d = -1;
    j = -1;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (f_pbl) begin
        d = n - 1;
        j = int'(f_jumped);
        break;
      end
    end
  endtask

  initial begin
    int p, d, j, misses;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_pbl", int'(pbl_AI), 0);
    checkOutput("reset_jumped", int'(jumped), 0);
    checkOutput("reset_armed", int'(armed), 0);
    checkOutput("reset_press_cnt", int'(press_cnt), 0);

    // Table-driven rounds: fixed levels, some switching to PLAY mid-wait.
    for (int i = 0; i < 6; i++) begin
      idle(3);
      beginRound(vecs[i].lv, 1'b0, vecs[i].exp_delay, vecs[i].exp_jumped, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("armed_wait_%0d", i), int'(armed), 1);
      if (vecs[i].play_at > 0) begin
        repeat (vecs[i].play_at - 1) @(negedge clk);
        state = 2'b10;
      end
      waitPress(2000);
      @(negedge clk);
      checkOutput($sformatf("press_cnt_%0d", i), int'(press_cnt), exp_press);
      checkOutput($sformatf("armed_done_%0d", i), int'(armed), 0);
      if (vecs[i].hold > 0) begin
        p = pulse_total;
        repeat (vecs[i].hold) @(negedge clk);
        checkOutput("no_second_press", pulse_total, p);
      end
    end

    // Abort at cycle 300 via a non-round state, then a fresh full-length round.
    idle(3);
    beginRound(2'd0, 1'b0, 1200, 1'b1, 1'b0);
    repeat (300) @(negedge clk);
    state = 2'b11;
    @(negedge clk);
    checkOutput("abort_armed", int'(armed), 0);
    p = pulse_total;
    repeat (1500) @(negedge clk);
    checkOutput("abort_no_press", pulse_total, p);
    beginRound(2'd0, 1'b0, 1200, 1'b1, 1'b1);
    waitPress(2000);

    // Jittered rounds against the reference LFSR.
    for (int i = 0; i < 20; i++) begin
      idle(2);
      beginRound(2'd0, 1'b1, 1200, 1'b1, 1'b1);
      waitPress(2000);
      checkOutput($sformatf("jitter_range_%0d", i),
                  int'(last_delay >= 1200 && last_delay <= 1455), 1);
    end
    @(negedge clk);
    checkOutput("press_cnt_after_jitter", int'(press_cnt), exp_press);

    // Dropping enable mid-wait cancels the round.
    idle(3);
    beginRound(2'd1, 1'b0, 944, 1'b1, 1'b0);
    repeat (100) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checkOutput("disable_armed", int'(armed), 0);
    p = pulse_total;
    repeat (1200) @(negedge clk);
    checkOutput("disable_no_press", pulse_total, p);

    // Asynchronous reset at cycle 600 of a round.
    idle(3);
    beginRound(2'd0, 1'b0, 1200, 1'b1, 1'b0);
    repeat (600) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_pbl", int'(pbl_AI), 0);
    checkOutput("rst_jumped", int'(jumped), 0);
    checkOutput("rst_armed", int'(armed), 0);
    checkOutput("rst_press_cnt", int'(press_cnt), 0);
    exp_press = 0;
    enable    = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    p = pulse_total;
    repeat (2000) @(negedge clk);
    checkOutput("dark_disabled_no_press", pulse_total, p);
    checkOutput("dark_disabled_armed", int'(armed), 0);

    // Enabling while DARK is already held is not a round start.
    enable = 1'b1;
    repeat (1500) @(negedge clk);
    checkOutput("held_dark_no_press", pulse_total, p);
    checkOutput("held_dark_armed", int'(armed), 0);

    // First DARK after reset release counts as a round start (LFSR back at SEED).
    rst = 1'b1;
    jitter_en = 1'b1;
    level = 2'd0;
    @(negedge clk);
    rst = 1'b0;
    start_pending = 1'b1;
    mon_e.delay  = 1200 + int'(ref_lfsr[7:0]);
    mon_e.jumped = 1'b1;
    sbq.push_back(mon_e);
    exp_press = 1;
    waitPress(2000);
    @(negedge clk);
    checkOutput("post_reset_press_cnt", int'(press_cnt), exp_press);
    jitter_en = 1'b0;
    state = 2'b01;

    // Short-delay instance: clamp at both ends of the counter range.
    for (int i = 0; i < 4; i++) begin
      fastRound(fvecs[i].lv, d, j);
      checkOutput($sformatf("fast_delay_lv%0d", fvecs[i].lv), d, fvecs[i].exp_delay);
      checkOutput($sformatf("fast_jumped_lv%0d", fvecs[i].lv), j, 1);
    end
    @(negedge clk);
    checkOutput("fast_press_cnt_4", int'(f_press_cnt), 4);
    checkOutput("fast_armed_done", int'(f_armed), 0);

    misses = 0;
    for (int i = 0; i < 246; i++) begin
      fastRound(2'd3, d, j);
      if (d != 2) misses++;
    end
    @(negedge clk);
    checkOutput("fast_press_cnt_250", int'(f_press_cnt), 250);
    for (int i = 0; i < 54; i++) begin
      fastRound(2'd3, d, j);
      if (d != 2) misses++;
    end
    @(negedge clk);
    checkOutput("fast_sat_misses", misses, 0);
    checkOutput("fast_press_cnt_sat", int'(f_press_cnt), 255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/battle_ai_gen.md
Name: battle_ai_gen

Overview:
- Parametrised AI opponent for the tug-of-war reaction game. It generates one push-button pulse per round after a delay set by difficulty level plus optional LFSR jitter.
- The delay counts from entry into the dark state, so the AI can press before the light (a "jump") if the play state arrives late.
- Sits beside the human push-button synchronisers. It drives the AI player's pbl input to the game FSM and reads the same 2-bit game state.

Parameters:
- CNT_W, 11: width of the delay counter and of the target register.
- BASE_DELAY, 1199: delay in cycles for level 0 (easiest).
- LEVEL_STEP, 256: cycles subtracted from BASE_DELAY per level step.
- JITTER_W, 8: number of LFSR bits added as random jitter.
- SEED, 16'hACE1: LFSR reset value. 0 is replaced by 16'h0001.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- state  in  2  game state: 2'b00 DARK, 2'b10 PLAY, 2'b01/2'b11 non-round states (score/idle).
- enable  in  1  AI participates when 1.
- level  in  2  difficulty 0..3; higher is faster.
- jitter_en  in  1  when 1, random jitter is added to the target.
- pbl_AI  out  1  one-cycle button pulse.
- jumped  out  1  one-cycle pulse coincident with pbl_AI when the press happens in DARK.
- armed  out  1  high while the AI is waiting to press in the current round.
- press_cnt  out  8  saturating count of presses since reset.

Behaviour:
- Reset (async): pbl_AI=0, jumped=0, armed=0, press_cnt=0, count=0, target=0, FSM=IDLE, lfsr=SEED, state_q=2'b01.
- state_q is the registered copy of state. A round start is `state==2'b00 && state_q!=2'b00 && enable` at a clock edge.
- LFSR: 16-bit Galois, taps 16'hB400, shifts every cycle regardless of FSM.
- Target computation at a round start:
  - t = BASE_DELAY - level*LEVEL_STEP + (jitter_en ? lfsr[JITTER_W-1:0] : 0), computed in CNT_W+2 signed bits.
  - Clamp to [1, 2^CNT_W-1]. Latch into target.
  - level and jitter_en are sampled only at round start.
- FSM states:
  - IDLE: armed=0. Round start -> ARMED with count<=0.
  - ARMED: armed=1. On each edge with state in {00,10}:
    - if count==target: pbl_AI<=1, jumped<=(state==2'b00), press_cnt<=press_cnt+1 (saturates at 255), go to DONE.
    - else count<=count+1.
  - DONE: armed=0, no further presses. A new round start -> ARMED.
- Exits:
  - From ARMED or DONE, state in {01,11} -> IDLE; count held, no press.
  - enable=0 at any edge -> IDLE, armed=0; a pulse already in flight still completes its single cycle.
- Latency: with round-start edge E0, pbl_AI is high from edge E0+target+1 until edge E0+target+2. It is never high for two consecutive cycles.
- Round start while ARMED (state went 00 -> 10 -> 00 without pressing) restarts: new target latched, count<=0.
- Round start while in DONE rearms the same way.
- A round start takes priority over the count==target check on the same edge.
- PLAY entry does not restart counting; the count continues from DARK.
- Reset mid-round: immediate return to reset values. The first DARK after reset release counts as a round start.
- Arithmetic: count is compared with equality only. It never exceeds target because target is at most 2^CNT_W-1, so there is no wrap-around.

Test Plan:
1. enable=1, level=0, jitter_en=0; state 01 -> 00 held. Expect a single pbl_AI pulse exactly 1200 cycles after the round-start edge, jumped=1, press_cnt=1.
2. Same round, but state -> 10 at cycle 500 after the round start. Expect pbl_AI at cycle 1200, jumped=0, and no second pulse while state stays 10 for 5000 cycles.
3. level=3, jitter_en=0. Expect the press 432 cycles after the round start. level=2 gives 688.
4. At cycle 300 of an ARMED round (level 0), state -> 11. Expect no pulse and armed=0. Return to 00 starts a new round with a fresh 1200-cycle delay.
5. jitter_en=1, SEED=16'hACE1, 20 rounds. Expect each delay equal to 1200 + lfsr[7:0] from the bench's reference LFSR model; all delays within 1200..1455.
6. Assert rst at cycle 600 of a round, then enable=0 during DARK, then press_cnt saturation test. Expect:
   - all outputs 0 immediately on rst;
   - no pulse while enable=0;
   - press_cnt stops at 255 after 300 rounds.
